dmem_ctl: RTL and testbench
===========================

# dmem_ctl

Byte-addressed, little-endian RV data memory that replaces the single-size `dmem` on the MEM stage. It supports:
- sized loads and stores (byte/half/word, plus double when WIDTH=64);
- sign or zero extension on loads;
- a one-cycle registered response with a valid pulse;
- a post-reset hardware clear sequence, during which the block is not ready.

It sits between the ALU address/rs2 datapath and the writeback mux.

## Interface
- WIDTH, 32, datapath width in bits; legal values 32 or 64.
- MEM_DEPTH, 1024, memory size in bytes; must be a power of two and a multiple of WIDTH/8.

Ports (clock and reset first):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- dmem_req  in  1  access request; accepted on an edge where dmem_req=1 and dmem_ready=1.
- dmem_we  in  1  1=store, 0=load.
- dmem_funct3  in  3  RV funct3 size/extension code.
- aluout  in  WIDTH  byte address.
- rs2_out  in  WIDTH  store data, LSB-aligned.
- dmem_ready  out  1  block can accept a request.
- dmem_valid  out  1  response pulse, one cycle per accepted request.
- dmem_out  out  WIDTH  load result; 0 for stores and faults.
- dmem_fault  out  1  accepted request was illegal or misaligned; qualified by dmem_valid.

## Operation
- States: CLEAR and IDLE.
- dmem_ready = (state==IDLE), decoded combinationally from state.
- CLEAR state:
  - A word counter cnt writes zero to bytes [cnt*WIDTH/8 +: WIDTH/8], one word per cycle.
  - On the edge that clears word MEM_DEPTH*8/WIDTH-1, state moves to IDLE.
  - For defaults, CLEAR lasts 256 cycles.
- Address index = aluout[log2(MEM_DEPTH)-1:0]. Upper address bits are ignored, so the address space aliases.
- funct3 codes:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011 D and 110 WU are legal only when WIDTH=64.
  - All other codes are illegal.
  - Stores with 1xx are illegal.
- Store: writes the low N bytes of rs2_out to index..index+N-1, little-endian. The write commits on the accept edge.
- Load:
  - Reads N bytes from the memory contents at the accept edge.
  - Signed codes sign-extend to WIDTH; U codes zero-extend.
  - Result is registered into dmem_out.
- Byte index arithmetic is modulo MEM_DEPTH; an access running past the top wraps to byte 0.
- Illegal funct3: no write; response has dmem_fault=1 and dmem_out=0. This holds in every configuration.
- Requests presented while dmem_ready=0 are ignored. No response is generated and no write occurs.

## Timing
- Reset: an edge with rst=1 forces the following:
  - state=CLEAR, cnt=0, dmem_valid=0, dmem_out=0, dmem_fault=0.
  - dmem_ready=0 from the next cycle.
  - Any request on that edge is dropped; a response due that cycle is dropped.
- Reset asserted mid-CLEAR restarts the clear at cnt=0.
- Request accepted at edge N: dmem_valid=1 with dmem_out and dmem_fault during cycle N+1. dmem_valid is 0 again after edge N+1 unless another request was accepted at N+1.
- Full throughput: one request per cycle, back-to-back.
- A load accepted at edge N+1 observes a store accepted at edge N to any overlapping bytes.
- dmem_out and dmem_fault hold their last values while dmem_valid=0.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: misaligned accesses fault, perform no write, and return dmem_out=0. Misaligned means:
  - H/HU/SH with index[0]≠0;
  - W/WU with index[1:0]≠0;
  - D with index[2:0]≠0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Misaligned accesses complete byte-wise at any address, including wrap past MEM_DEPTH-1.
  - dmem_fault is driven only by illegal funct3.

## Test plan
- Reset then clear: rst=1 for 1 edge, then low.
  - dmem_ready=0 for exactly 256 cycles, then 1.
  - LW at 0x3FC returns 0x00000000.
- Store-then-load: SW 0x0 ← 0xDEADBEEF; next cycle LW 0x0 → 0xDEADBEEF; LB 0x0 → 0xFFFFFFEF; LBU 0x3 → 0x000000DE; LH 0x2 → 0xFFFFDEAD.
- Back-to-back sizing:
  - SB 0x5 ← 0x000000AA, SH 0x6 ← 0x00001234, LW 0x4 on consecutive cycles.
  - Load returns 0x1234AA00.
  - dmem_valid high for 3 consecutive cycles.
- Misaligned LW 0x1 with rs2 irrelevant:
  - With macro: dmem_fault=1, dmem_out=0, memory unchanged.
  - Without macro: returns bytes 1..4.
  - Without macro, SW 0x3FE ← 0x11223344 then LW 0x3FE → 0x11223344, with bytes landing at 0x3FE, 0x3FF, 0x000, 0x001.
- Illegal funct3: store with funct3=100, or load with funct3=111 at WIDTH=32 → dmem_fault=1; no memory change.
- Reset mid-stream: assert rst on the edge a store is presented.
  - Store is not performed.
  - dmem_valid=0 the following cycle.
  - CLEAR runs the full 256 cycles again.

Source files
------------

// File: rtl/dmem_ctl.sv
// Byte-addressed little-endian data memory with sized loads/stores, one-cycle registered response
// and a post-reset clear sequence. Optional macro DMEM_MISALIGN_TRAP_EN makes misaligned accesses fault.
module dmem_ctl #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmem_req,
  input  logic             dmem_we,
  input  logic [2:0]       dmem_funct3,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] rs2_out,
  output logic             dmem_ready,
  output logic             dmem_valid,
  output logic [WIDTH-1:0] dmem_out,
  output logic             dmem_fault
);

  localparam int BPW   = WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(BPW);
  localparam int CNT_W = IDX_W - OFF_W;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       mem [MEM_DEPTH];

  logic [IDX_W-1:0] idx_p0;
  logic [3:0]       nbytes_p0;
  logic             sgn_p0;
  logic             illegal_p0;
  logic             misalign_p0;
  logic             fault_p0;
  logic             accept_p0;
  logic [WIDTH-1:0] raw_p0;
  logic [WIDTH-1:0] ld_p0;
  logic             unused_addr;

  // Right-justify the low nb bytes of raw and extend them to WIDTH.
  function automatic logic [WIDTH-1:0] ext_load(input logic [WIDTH-1:0] raw,
                                                input logic [3:0] nb, input logic sgn);
    int                      sh;
    logic signed [WIDTH-1:0] aligned;
    logic        [WIDTH-1:0] up;
    sh      = WIDTH - 8 * int'(nb);
    up      = raw << sh;
    aligned = signed'(up);
    return sgn ? $unsigned(aligned >>> sh) : (up >> sh);
  endfunction

  assign unused_addr = ^aluout[WIDTH-1:IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CLEAR) ? cnt + CNT_W'(1) : cnt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == CNT_LAST) state_nxt = IDLE;
  end

  always_comb begin
    dmem_ready = (state == IDLE);
  end

  // p0: request decode and combinational read of the addressed bytes
  assign idx_p0 = aluout[IDX_W-1:0];

  always_comb begin
    nbytes_p0  = 4'd0;
    sgn_p0     = 1'b0;
    illegal_p0 = 1'b0;
    case (dmem_funct3)
      3'b000: begin nbytes_p0 = 4'd1; sgn_p0 = 1'b1; end
      3'b001: begin nbytes_p0 = 4'd2; sgn_p0 = 1'b1; end
      3'b010: begin nbytes_p0 = 4'd4; sgn_p0 = 1'b1; end
      3'b011: begin nbytes_p0 = 4'd8; sgn_p0 = 1'b1; illegal_p0 = (WIDTH != 64); end
      3'b100: nbytes_p0 = 4'd1;
      3'b101: nbytes_p0 = 4'd2;
      3'b110: begin nbytes_p0 = 4'd4; illegal_p0 = (WIDTH != 64); end
      default: illegal_p0 = 1'b1;
    endcase
    if (dmem_we && dmem_funct3[2]) illegal_p0 = 1'b1;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (nbytes_p0)
      4'd2:    misalign_p0 = idx_p0[0];
      4'd4:    misalign_p0 = |idx_p0[1:0];
      4'd8:    misalign_p0 = |idx_p0[2:0];
      default: misalign_p0 = 1'b0;
    endcase
  end
`else
  assign misalign_p0 = 1'b0;
`endif

  assign fault_p0  = illegal_p0 | misalign_p0;
  assign accept_p0 = dmem_req & dmem_ready & ~rst;

  // Byte lanes wrap modulo MEM_DEPTH through the IDX_W-bit index addition.
  always_comb begin
    raw_p0 = '0;
    for (int i = 0; i < BPW; i++) raw_p0[i*8 +: 8] = mem[idx_p0 + IDX_W'(i)];
  end

  assign ld_p0 = ext_load(raw_p0, nbytes_p0, sgn_p0);

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int i = 0; i < BPW; i++) mem[{cnt, OFF_W'(i)}] <= '0;
    end else if (accept_p0 && dmem_we && !fault_p0) begin
      for (int i = 0; i < BPW; i++)
        if (i < int'(nbytes_p0)) mem[idx_p0 + IDX_W'(i)] <= rs2_out[i*8 +: 8];
    end
  end

  // p1: registered response; data holds while no response is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_valid <= 1'b0;
      dmem_out   <= '0;
      dmem_fault <= 1'b0;
    end else if (accept_p0) begin
      dmem_valid <= 1'b1;
      dmem_fault <= fault_p0;
      dmem_out   <= (fault_p0 || dmem_we) ? '0 : ld_p0;
    end else begin
      dmem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_ctl.sv
// Self-checking bench for dmem_ctl: directed vector table, reset/clear sequences and
// randomized traffic checked against a byte-array reference model.
module tb_dmem_ctl;
  localparam int W     = 32;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         dmem_req, dmem_we;
  logic [2:0]   dmem_funct3;
  logic [W-1:0] aluout, rs2_out;
  logic         dmem_ready, dmem_valid, dmem_fault;
  logic [W-1:0] dmem_out;

  dmem_ctl #(.WIDTH(W), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_funct3(dmem_funct3), .aluout(aluout), .rs2_out(rs2_out),
    .dmem_ready(dmem_ready), .dmem_valid(dmem_valid), .dmem_out(dmem_out),
    .dmem_fault(dmem_fault)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   mm [DEPTH];
  logic [W-1:0] last_out;
  logic         last_fault;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] eo;
    logic        ef;
  } vec_t;
  vec_t tv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a flat byte array, sizes and legality from the RV funct3 rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [W-1:0] a,
                       input logic [W-1:0] d, output logic [W-1:0] eo, output logic ef);
    int          n, idx;
    bit          s, leg;
    logic [63:0] v;
    idx = int'(a % DEPTH);
    n = 0; s = 0; leg = 1;
    case (f3)
      3'd0: begin n = 1; s = 1; end
      3'd1: begin n = 2; s = 1; end
      3'd2: begin n = 4; s = 1; end
      3'd3: begin n = 8; s = 1; leg = (W == 64); end
      3'd4: n = 1;
      3'd5: n = 2;
      3'd6: begin n = 4; leg = (W == 64); end
      default: leg = 0;
    endcase
    if (we && f3 >= 3'd4) leg = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (leg && n > 1 && (idx % n) != 0) leg = 0;
`endif
    eo = '0;
    ef = !leg;
    if (!leg) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[(idx + i) % DEPTH] = d[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v + (64'(mm[(idx + i) % DEPTH]) << (8 * i));
      if (s && n < 8 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      eo = v[W-1:0];
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] eo, input logic ef);
    vec_t t;
    t.we = we; t.f3 = f3; t.addr = a; t.data = d; t.eo = eo; t.ef = ef;
    tv.push_back(t);
  endtask

  task automatic op(input logic req, input logic we, input logic [2:0] f3,
                    input logic [W-1:0] a, input logic [W-1:0] d, input string name);
    logic [W-1:0] eo;
    logic         ef;
    dmem_req = req; dmem_we = we; dmem_funct3 = f3; aluout = a; rs2_out = d;
    if (req) model(we, f3, a, d, eo, ef);
    @(posedge clk); #1;
    if (req) begin
      check({name, " valid"}, 64'(dmem_valid), 64'd1);
      check({name, " out"},   64'(dmem_out),   64'(eo));
      check({name, " fault"}, 64'(dmem_fault), 64'(ef));
      last_out = eo; last_fault = ef;
    end else begin
      check({name, " idle valid"}, 64'(dmem_valid), 64'd0);
      check({name, " hold out"},   64'(dmem_out),   64'(last_out));
      check({name, " hold fault"}, 64'(dmem_fault), 64'(last_fault));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int           n, vseen;
    logic [W-1:0] eo;
    logic         ef;
    logic [31:0]  a;

    rst = 1'b1; dmem_req = 1'b0; dmem_we = 1'b0; dmem_funct3 = 3'd0; aluout = '0; rs2_out = '0;
    @(posedge clk); #1;
    check("rst ready", 64'(dmem_ready), 64'd0);
    check("rst valid", 64'(dmem_valid), 64'd0);
    check("rst out",   64'(dmem_out),   64'd0);
    check("rst fault", 64'(dmem_fault), 64'd0);
    rst = 1'b0;
    n = 0;
    while (!dmem_ready && n < 1000) begin n++; @(posedge clk); #1; end
    check("clear cycles", 64'(n), 64'd256);
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    last_out = '0; last_fault = 1'b0;

    add(0, 3'b010, 32'h3FC, 0, 32'h0, 0);
    add(1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    add(0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 0);
    add(0, 3'b000, 32'h0, 0, 32'hFFFFFFEF, 0);
    add(0, 3'b100, 32'h3, 0, 32'h000000DE, 0);
    add(0, 3'b001, 32'h2, 0, 32'hFFFFDEAD, 0);
    add(1, 3'b000, 32'h5, 32'h000000AA, 32'h0, 0);
    add(1, 3'b001, 32'h6, 32'h00001234, 32'h0, 0);
    add(0, 3'b010, 32'h4, 0, 32'h1234AA00, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, 3'b010, 32'h1, 32'h55555555, 32'h0, 1);
    add(1, 3'b010, 32'h3FE, 32'h11223344, 32'h0, 1);
    add(0, 3'b010, 32'h3FE, 0, 32'h0, 1);
    add(0, 3'b100, 32'h0, 0, 32'hEF, 0);
    add(0, 3'b100, 32'h1, 0, 32'hBE, 0);
    add(0, 3'b100, 32'h3FF, 0, 32'h00, 0);
`else
    add(0, 3'b010, 32'h1, 32'h55555555, 32'h00DEADBE, 0);
    add(1, 3'b010, 32'h3FE, 32'h11223344, 32'h0, 0);
    add(0, 3'b010, 32'h3FE, 0, 32'h11223344, 0);
    add(0, 3'b100, 32'h0, 0, 32'h22, 0);
    add(0, 3'b100, 32'h1, 0, 32'h11, 0);
    add(0, 3'b100, 32'h3FF, 0, 32'h33, 0);
`endif
    add(0, 3'b101, 32'h2, 0, 32'h0000DEAD, 0);
    add(1, 3'b100, 32'h8, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 3'b010, 32'h8, 0, 32'h0, 0);
    add(0, 3'b111, 32'h0, 0, 32'h0, 1);
    add(0, 3'b011, 32'h0, 0, 32'h0, 1);
    add(0, 3'b110, 32'h0, 0, 32'h0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, 3'b010, 32'h0, 0, 32'hDEADBEEF, 0);
`else
    add(0, 3'b010, 32'h0, 0, 32'hDEAD1122, 0);
`endif

    foreach (tv[k]) begin
      dmem_req = 1'b1; dmem_we = tv[k].we; dmem_funct3 = tv[k].f3;
      aluout = tv[k].addr; rs2_out = tv[k].data;
      model(tv[k].we, tv[k].f3, tv[k].addr, tv[k].data, eo, ef);
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", k), 64'(dmem_valid), 64'd1);
      check($sformatf("vec%0d out", k),   64'(dmem_out),   64'(tv[k].eo));
      check($sformatf("vec%0d fault", k), 64'(dmem_fault), 64'(tv[k].ef));
      last_out = tv[k].eo; last_fault = tv[k].ef;
    end
    op(0, 0, 3'b010, 32'h0, 0, "gap");

    // Reset on the edge a store is presented, with a response from the previous edge pending.
    op(1, 0, 3'b010, 32'h0, 0, "pre-rst load");
    rst = 1'b1; dmem_req = 1'b1; dmem_we = 1'b1; dmem_funct3 = 3'b010;
    aluout = 32'h10; rs2_out = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("midrst valid", 64'(dmem_valid), 64'd0);
    check("midrst ready", 64'(dmem_ready), 64'd0);
    check("midrst out",   64'(dmem_out),   64'd0);
    rst = 1'b0;
    n = 0; vseen = 0;
    while (!dmem_ready && n < 1000) begin
      n++; @(posedge clk); #1;
      if (dmem_valid) vseen++;
    end
    dmem_req = 1'b0;
    check("reclear cycles", 64'(n), 64'd256);
    check("ignored reqs", 64'(vseen), 64'd0);
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    last_out = '0; last_fault = 1'b0;
    op(1, 0, 3'b010, 32'h10, 0, "post-clear lw10");
    op(1, 0, 3'b010, 32'h0, 0, "post-clear lw0");

    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 31));
        1:       a = 32'($urandom_range(DEPTH - 32, DEPTH - 1));
        default: a = 32'($urandom_range(0, DEPTH - 1));
      endcase
      a = a | ($urandom << 10);
      op($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         a, $urandom, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
